// File: rtl/traffic_pkg.sv
// Shared types, default intervals and lamp decode for the intersection phase scheduler.
package traffic_pkg;

    typedef enum logic [2:0] {
        ARBA  = 3'd0,   // all-red, A gets the next green
        A_GRN = 3'd1,
        A_YEL = 3'd2,
        ARAB  = 3'd3,   // all-red, B gets the next green
        B_GRN = 3'd4,
        B_YEL = 3'd5,
        PED   = 3'd6
    } phase_t;

    // Default interval lengths, in ticks
    localparam int DEF_MIN_GREEN = 4;
    localparam int DEF_MAX_GREEN = 10;
    localparam int DEF_YELLOW    = 3;
    localparam int DEF_ALL_RED   = 2;
    localparam int DEF_WALK      = 5;

    // Largest of the five intervals; sizes the shared interval timer
    function automatic int max5(input int a, input int b, input int c, input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

    // Phase to lamps, packed as {Ra, Ga, Ya, Rb, Gb, Yb, walk}
    function automatic logic [6:0] lamp_decode(input phase_t ph);
        logic [6:0] lamps;
        lamps = 7'b100_100_0;
        case (ph)
            A_GRN:   lamps = 7'b010_100_0;
            A_YEL:   lamps = 7'b001_100_0;
            B_GRN:   lamps = 7'b100_010_0;
            B_YEL:   lamps = 7'b100_001_0;
            PED:     lamps = 7'b100_100_1;
            default: lamps = 7'b100_100_0;
        endcase
        return lamps;
    endfunction

endpackage

// File: rtl/traffic_interval_timer.sv
// Tick-gated interval counter: synchronous clear, counts ticks, saturates at LIMIT.
module traffic_interval_timer #(
    parameter int WIDTH = 5,
    parameter int LIMIT = 9
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             tick,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    // Clear wins over counting; counting only on tick and only below the limit
    always_ff @(posedge clk) begin
        if (srst || clear) begin
            count_reg <= '0;
        end else if (tick && (count_reg != WIDTH'(LIMIT))) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-road intersection phase scheduler with actuated greens and latched pedestrian walk.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN = DEF_MIN_GREEN,
    parameter int MAX_GREEN = DEF_MAX_GREEN,
    parameter int YELLOW    = DEF_YELLOW,
    parameter int ALL_RED   = DEF_ALL_RED,
    parameter int WALK      = DEF_WALK
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       Sa,
    input  logic       Sb,
    input  logic       ped_req,
    output logic       Ra,
    output logic       Ga,
    output logic       Ya,
    output logic       Rb,
    output logic       Gb,
    output logic       Yb,
    output logic       walk,
    output logic [2:0] phase
);

    localparam int DMAX = max5(MIN_GREEN, MAX_GREEN, YELLOW, ALL_RED, WALK);
    localparam int TW   = $clog2(DMAX) + 1;

    // Reject interval settings the sequencing cannot honour
    generate
        if ((MIN_GREEN < 1) || (MAX_GREEN < MIN_GREEN) || (YELLOW < 1) ||
            (ALL_RED < 1) || (WALK < 1)) begin : g_bad_params
            $error("traffic_phase_scheduler: illegal interval parameters");
        end
    endgenerate

    phase_t        state_reg;
    phase_t        state_next;
    logic          ped_pending_reg;
    logic          ped_pending_next;
    logic          next_is_b_reg;
    logic          next_is_b_next;
    logic          state_change;
    logic          demand_a;
    logic          demand_b;
    logic [TW-1:0] timer;

    assign demand_a = Sa | ped_pending_reg;
    assign demand_b = Sb | ped_pending_reg;

    // Timer restarts on every phase change; it saturates at the longest interval so
    // a resting green keeps reading "max-out reached" once MAX_GREEN has elapsed.
    traffic_interval_timer #(
        .WIDTH (TW),
        .LIMIT (DMAX - 1)
    ) u_timer (
        .clk   (clk),
        .srst  (reset),
        .tick  (tick),
        .clear (state_change),
        .count (timer)
    );

    // State, pending pedestrian request and post-walk road selection
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ARBA;
            ped_pending_reg <= 1'b0;
            next_is_b_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            ped_pending_reg <= ped_pending_next;
            next_is_b_reg   <= next_is_b_next;
        end
    end

    // Next-phase decision, evaluated only on tick; a new button press beats the entry clear
    always_comb begin
        state_next     = state_reg;
        next_is_b_next = next_is_b_reg;
        if (tick) begin
            case (state_reg)
                ARBA: begin
                    if (timer == TW'(ALL_RED - 1)) begin
                        if (ped_pending_reg) begin
                            state_next     = PED;
                            next_is_b_next = 1'b0;
                        end else begin
                            state_next = A_GRN;
                        end
                    end
                end
                A_GRN: begin
                    if (demand_b && (((timer >= TW'(MIN_GREEN - 1)) && !Sa) ||
                                     (timer >= TW'(MAX_GREEN - 1)))) begin
                        state_next = A_YEL;
                    end
                end
                A_YEL: begin
                    if (timer == TW'(YELLOW - 1)) state_next = ARAB;
                end
                ARAB: begin
                    if (timer == TW'(ALL_RED - 1)) begin
                        if (ped_pending_reg) begin
                            state_next     = PED;
                            next_is_b_next = 1'b1;
                        end else begin
                            state_next = B_GRN;
                        end
                    end
                end
                B_GRN: begin
                    if (demand_a && (((timer >= TW'(MIN_GREEN - 1)) && !Sb) ||
                                     (timer >= TW'(MAX_GREEN - 1)))) begin
                        state_next = B_YEL;
                    end
                end
                B_YEL: begin
                    if (timer == TW'(YELLOW - 1)) state_next = ARBA;
                end
                PED: begin
                    if (timer == TW'(WALK - 1)) state_next = next_is_b_reg ? B_GRN : A_GRN;
                end
                default: state_next = ARBA;
            endcase
        end
        state_change     = (state_next != state_reg);
        ped_pending_next = ped_req |
                           (ped_pending_reg & ~(state_change && (state_next == PED)));
    end

    // Moore lamp outputs decoded from the registered phase only
    assign {Ra, Ga, Ya, Rb, Gb, Yb, walk} = lamp_decode(state_reg);
    assign phase = state_reg;

endmodule
